// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in / serial-out transmitter.
// Contents: FSM state type, default frame width, counter-width helper.
package piso_pkg;

    localparam int unsigned PISO_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } piso_state_e;

    // Bit-counter width for a frame of `width` data bits (at least one bit).
    function automatic int unsigned piso_cnt_w(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Data-bit counter for piso_tx: tracks which data bit is on the serial line.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   i_clear      force count to 0 (priority over i_enable)
//   i_enable     advance to the next bit
//   o_last_c     combinational flag: count is on the final data bit (WIDTH-1)
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = PISO_WIDTH_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_last_c
);

    localparam int unsigned CNT_W = piso_cnt_w(WIDTH);

    logic [CNT_W-1:0] r_count;

    // Count register; enable is never asserted on the last bit, so no wrap occurs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_last_c = (r_count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/piso_tx.sv
// Parallel-in / serial-out transmitter with valid/ready load handshake.
// Optional feature: define PISO_TX_PARITY_EN to append one even-parity bit
// to every frame (frame length WIDTH+1 instead of WIDTH).
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   load_data     parallel word to serialize
//   load_valid    producer offers load_data this cycle
//   load_ready    combinational: a word is accepted on this edge if valid
//   data_out      registered serial bit stream (0 when idle)
//   frame_out     registered, high while data_out carries a frame bit
//   done          registered one-cycle pulse after the final frame bit
module piso_tx
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = PISO_WIDTH_DEFAULT,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             data_out,
    output logic             frame_out,
    output logic             done
);

    piso_state_e      r_state, w_state_nxt;
    logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
    logic             r_dout, w_dout_nxt;
    logic             r_frame, w_frame_nxt;
    logic             r_done, w_done_nxt;
`ifdef PISO_TX_PARITY_EN
    logic             r_parity, w_parity_nxt;
`endif

    logic             w_cnt_clear;
    logic             w_cnt_en;
    logic             w_last;
    logic             w_xfer;
    logic             w_load;
    logic             w_first_bit;
    logic             w_next_bit;
    logic [WIDTH-1:0] w_shifted;

    piso_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_cnt_clear),
        .i_enable (w_cnt_en),
        .o_last_c (w_last)
    );

    // The register holds the whole word; the bit already on data_out is the
    // one at the leading end, so the next bit is one position in.
    assign w_first_bit = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
    assign w_next_bit  = MSB_FIRST ? r_shreg[WIDTH-2]   : r_shreg[1];
    assign w_shifted   = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                                   : {1'b0, r_shreg[WIDTH-1:1]};

    // Ready depends on state and counter only, never on load_valid.
    always_comb begin
        load_ready = 1'b0;
        case (r_state)
            IDLE:   load_ready = 1'b1;
`ifdef PISO_TX_PARITY_EN
            PARITY: load_ready = 1'b1;
`else
            SHIFT:  load_ready = w_last;
`endif
            default: load_ready = 1'b0;
        endcase
    end

    assign w_xfer = load_valid & load_ready;

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_shreg_nxt  = r_shreg;
        w_dout_nxt   = 1'b0;
        w_frame_nxt  = 1'b0;
        w_done_nxt   = 1'b0;
        w_cnt_clear  = 1'b0;
        w_cnt_en     = 1'b0;
        w_load       = 1'b0;
`ifdef PISO_TX_PARITY_EN
        w_parity_nxt = r_parity;
`endif
        case (r_state)
            IDLE: begin
                w_load = w_xfer;
            end
            SHIFT: begin
                if (!w_last) begin
                    w_shreg_nxt = w_shifted;
                    w_dout_nxt  = w_next_bit;
                    w_frame_nxt = 1'b1;
                    w_cnt_en    = 1'b1;
                end else begin
`ifdef PISO_TX_PARITY_EN
                    w_state_nxt = PARITY;
                    w_dout_nxt  = r_parity;
                    w_frame_nxt = 1'b1;
                    w_cnt_clear = 1'b1;
`else
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                    w_cnt_clear = 1'b1;
                    w_load      = w_xfer;
`endif
                end
            end
`ifdef PISO_TX_PARITY_EN
            PARITY: begin
                w_state_nxt = IDLE;
                w_done_nxt  = 1'b1;
                w_load      = w_xfer;
            end
`endif
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Accepted word: first bit goes straight onto the line next cycle.
        if (w_load) begin
            w_state_nxt  = SHIFT;
            w_shreg_nxt  = load_data;
            w_dout_nxt   = w_first_bit;
            w_frame_nxt  = 1'b1;
            w_cnt_clear  = 1'b1;
`ifdef PISO_TX_PARITY_EN
            w_parity_nxt = ^load_data;
`endif
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_shreg  <= '0;
            r_dout   <= 1'b0;
            r_frame  <= 1'b0;
            r_done   <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_shreg  <= w_shreg_nxt;
            r_dout   <= w_dout_nxt;
            r_frame  <= w_frame_nxt;
            r_done   <= w_done_nxt;
`ifdef PISO_TX_PARITY_EN
            r_parity <= w_parity_nxt;
`endif
        end
    end

    assign data_out  = r_dout;
    assign frame_out = r_frame;
    assign done      = r_done;

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 8, number of data bits per frame (legal range 2..32).
REQ-002 Parameter MSB_FIRST, default 1; 1 shifts bit WIDTH-1 first, 0 shifts bit 0 first.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 load_data  input  WIDTH  parallel word to serialize.
REQ-006 load_valid  input  1  producer offers load_data this cycle.
REQ-007 load_ready  output  1  block accepts a word this cycle.
REQ-008 data_out  output  1  serial bit stream, registered.
REQ-009 frame_out  output  1  high on every cycle data_out carries a frame bit.
REQ-010 done  output  1  one-cycle pulse on the cycle after the last frame bit.

Function
REQ-011 Handshake: a word transfers on a rising edge where load_valid=1 and load_ready=1; no transfer otherwise.
REQ-012 load_ready = 1 in IDLE, and in SHIFT during the final frame bit (back-to-back); 0 at all other times; combinational from state and counter only, never from load_valid.
REQ-013 States: IDLE, SHIFT; optional PARITY (see REQ-024).
REQ-014 IDLE -> SHIFT on transfer; shift register <= load_data, bit counter <= 0.
REQ-015 Latency: first bit appears on data_out with frame_out=1 in the cycle after the transfer edge.
REQ-016 In SHIFT, one bit per cycle, order per MSB_FIRST; bit counter increments per bit; exactly WIDTH bits per frame.
REQ-017 Last data bit (counter = WIDTH-1): if a transfer occurs on that edge, reload and remain in SHIFT with no gap cycle; else -> IDLE.
REQ-018 done pulses 1 in the cycle after the last frame bit, including the back-to-back case where frame_out stays high.
REQ-019 In IDLE: data_out=0, frame_out=0.
REQ-020 load_data changes while not transferring have no effect on the frame in flight.
REQ-021 Counter width = clog2(WIDTH); no wrap beyond WIDTH-1 is ever reached.

Reset
REQ-022 rst=0 forces, asynchronously and at any point including mid-frame: state=IDLE, shift register=0, counter=0, data_out=0, frame_out=0, done=0, and load_ready=1 once rst returns to 1.
REQ-023 A frame interrupted by reset is discarded; no done pulse is generated for it.

Configuration
REQ-024 Macro PISO_TX_PARITY_EN defined: after the last data bit, state PARITY emits one even-parity bit (XOR of the word) with frame_out=1; the back-to-back reload and the done pulse move to that bit; frame length = WIDTH+1.
REQ-025 Macro undefined: no PARITY state and no parity logic; frame length = WIDTH.

Structure
REQ-026 Shared package piso_pkg holds the state enum typedef (IDLE, SHIFT, PARITY) and the WIDTH default constant.
REQ-027 One sub-module, piso_bit_counter (clear, enable, last-bit flag), is instantiated for bit counting; the rest is flat.

Verification
REQ-028 WIDTH=8, MSB_FIRST=1, load 8'hB5 -> data_out 1,0,1,1,0,1,0,1 on 8 cycles with frame_out=1; done pulses on cycle 9.
REQ-029 MSB_FIRST=0, load 8'hB5 -> data_out 1,0,1,0,1,1,0,1; done after bit 8.
REQ-030 load_valid held high with words 8'hFF then 8'h00 -> 16 contiguous frame_out=1 cycles, no gap; done pulses on the first cycle of the second frame and again after its last bit.
REQ-031 rst driven to 0 during bit 4 of 8'hA5 -> data_out=0 and frame_out=0 immediately; no done; the next load of 8'h3C serializes cleanly.
REQ-032 PISO_TX_PARITY_EN defined, load 8'h07 -> 8 data bits followed by parity bit 1; frame_out high for 9 cycles.
REQ-033 load_valid=1 asserted mid-frame (not on the last bit) -> load_ready=0 and the word is held until the last bit, then accepted.
